// File: rtl/regfile_param_pkg.sv
// Shared definitions for the parametrised register bank: sequencer state
// encoding and the hardwired-zero register address.
package regfile_param_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    localparam int ZERO_ADDR = 0;

endpackage

// File: rtl/regfile_clr_seq.sv
// Post-reset clear sequencer: walks indices 1..NREGS-1 one per clock,
// emitting a zeroing write each cycle, then raises ready and parks in RUN.
module regfile_clr_seq
    import regfile_param_pkg::*;
#(
    parameter  int NREGS = 32,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst,
    output state_e        state,
    output logic          ready,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);

    state_e        state_nxt;
    logic [AW-1:0] clr_idx;
    logic [AW-1:0] idx_nxt;
    logic          ready_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_CLEAR;
            clr_idx <= AW'(1);
            ready   <= 1'b0;
        end else begin
            state   <= state_nxt;
            clr_idx <= idx_nxt;
            ready   <= ready_nxt;
        end
    end

    // The last index is written on the same edge that moves to RUN, so ready
    // rises exactly NREGS-1 edges after reset is released.
    always_comb begin
        state_nxt = state;
        idx_nxt   = clr_idx;
        ready_nxt = ready;
        clr_we    = 1'b0;
        clr_addr  = clr_idx;
        case (state)
            ST_CLEAR: begin
                clr_we = 1'b1;
                if (clr_idx == AW'(NREGS - 1)) begin
                    state_nxt = ST_RUN;
                    ready_nxt = 1'b1;
                end else begin
                    idx_nxt = clr_idx + 1'b1;
                end
            end
            ST_RUN: begin
                state_nxt = ST_RUN;
            end
            default: begin
                state_nxt = ST_CLEAR;
            end
        endcase
    end

endmodule

// File: rtl/regfile_param.sv
// Parametrised register bank: two combinational read ports, one synchronous
// write port, x0 hardwired to zero, and a post-reset clear sweep gating ready.
// Optional REGFILE_BYPASS_EN forwards same-cycle write data to the read ports.
module regfile_param
    import regfile_param_pkg::*;
#(
    parameter  int XLEN  = 32,
    parameter  int NREGS = 32,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            WE3,
    input  logic [AW-1:0]   A1,
    input  logic [AW-1:0]   A2,
    input  logic [AW-1:0]   A3,
    input  logic [XLEN-1:0] WD3,
    output logic [XLEN-1:0] RD1,
    output logic [XLEN-1:0] RD2,
    output logic            ready
);

    // Handshake: ready=1 means the bank is fully cleared; writes are accepted
    // and reads return array contents. While ready=0, WE3 is dropped (never
    // queued) and both read ports return zero.

    logic [XLEN-1:0] regs [NREGS];
    state_e          seq_state;
    logic            clr_we;
    logic [AW-1:0]   clr_addr;
    logic            run;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [XLEN-1:0] wr_data;

    regfile_clr_seq #(
        .NREGS (NREGS)
    ) u_clr_seq (
        .clk      (clk),
        .rst      (rst),
        .state    (seq_state),
        .ready    (ready),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    assign run = (seq_state == ST_RUN);

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = clr_addr;
        wr_data = '0;
        if (clr_we) begin
            wr_en = 1'b1;
        end else if (run && WE3 && (A3 != AW'(ZERO_ADDR))) begin
            wr_en   = 1'b1;
            wr_addr = A3;
            wr_data = WD3;
        end
    end

    // The array itself has no reset; the sweep is what scrubs it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] a);
        logic [XLEN-1:0] v;
        v = '0;
        if (ready && (a != AW'(ZERO_ADDR))) begin
            v = regs[a];
`ifdef REGFILE_BYPASS_EN
            if (WE3 && (A3 == a)) begin
                v = WD3;
            end
`endif
        end
        return v;
    endfunction

    always_comb begin
        RD1 = read_port(A1);
        RD2 = read_port(A2);
    end

endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
- Parametrised successor to the single-cycle RISC-V register bank: 2 async read ports, 1 sync write port, with configurable width and depth.
- Register 0 is hardwired to zero.
- After reset, a clear sequencer zeroes every register one per cycle. It raises `ready` only when the whole bank is clean, so there are no X values in simulation or on FPGA.
- Sits between decode and the ALU/writeback path of the single-cycle core. The core holds off retirement until `ready` is high.

Parameters:
- XLEN, 32, data width of each register in bits.
- NREGS, 32, number of registers; power of two, minimum 2.
- AW, $clog2(NREGS), address width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset; asynchronous, active-high (already decided). Starts a clear sweep.
- WE3  in  1  write enable.
- A1  in  AW  read address, port 1.
- A2  in  AW  read address, port 2.
- A3  in  AW  write address.
- WD3  in  XLEN  write data.
- RD1  out  XLEN  read data, port 1.
- RD2  out  XLEN  read data, port 2.
- ready  out  1  bank cleared and accepting writes.

Behaviour:
- State machine, 2 states: CLEAR, RUN.
- While rst=1:
  - state=CLEAR, clr_idx=1, ready=0.
  - RD1 and RD2 forced to 0.
  - The array is not touched asynchronously.
- CLEAR state:
  - On each rising edge, regs[clr_idx] <= 0 and clr_idx increments.
  - When clr_idx == NREGS-1 is written, the next state is RUN and ready=1 (registered).
  - ready therefore rises exactly NREGS-1 edges after rst deasserts (31 for the default).
- In CLEAR:
  - WE3 is ignored, with no queuing.
  - RD1 and RD2 read as 0 regardless of address.
- RUN state:
  - Writes: on a rising edge, if WE3=1 and A3!=0, regs[A3] <= WD3.
  - Reads: combinational, RD1=regs[A1], RD2=regs[A2].
  - Any read of address 0 returns 0, independent of array contents.
- rst asserted mid-CLEAR or mid-RUN: immediate return to CLEAR, ready drops in the same delta, and the sweep restarts at index 1.
- Write to address 0 is silently dropped; no error flag.
- Same-cycle write and read of the same address (without the optional feature): reads return the old value. The new value is visible after the edge.
- NREGS=2 boundary: the sweep clears only index 1, and ready rises 1 edge after rst deasserts.
- Address width rule: all addresses are exactly AW bits, with no out-of-range handling needed.
- Reset values of outputs: RD1=0, RD2=0, ready=0.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-through forwarding in RUN.
  - If WE3=1, A3!=0 and A3==A1, then RD1=WD3 combinationally.
  - The same rule applies to A2 and RD2.
  - This lets a pipelined core read the value being written in the same cycle.
  - Address 0 is never forwarded.
  - No forwarding in CLEAR.
- Undefined: no forwarding logic; reads return the pre-edge array contents.

Decomposition:
- Shared package/include file holds:
  - the state encoding constants ST_CLEAR=1'b0 and ST_RUN=1'b1;
  - the localparam ZERO_ADDR=0.
- One sub-module, `regfile_clr_seq`, is natural. It owns state, clr_idx and ready, and outputs clr_we and clr_addr.
  - The top muxes the write port between the sequencer and WE3/A3/WD3.
- The array and read logic stay in the top.

Test Plan:
- Clear sweep: pulse rst for 2 cycles, release, count edges → ready=0 for 30 edges, ready=1 after edge 31. Then every A1 in 0..31 reads 0x00000000.
- Basic write/read: in RUN, write A3=5, WD3=0xDEADBEEF → after the edge, A1=5 gives RD1=0xDEADBEEF and A2=5 gives RD2=0xDEADBEEF.
- x0 protection: write A3=0, WD3=0xFFFFFFFF → RD1 with A1=0 stays 0x00000000.
- Write during CLEAR: assert WE3, A3=7, WD3=0x12345678 at edge 3 after rst → once ready=1, A1=7 reads 0x00000000.
- Reset mid-RUN and mid-CLEAR:
  - Write 0xA5A5A5A5 to reg 9, assert rst → ready=0 immediately, and after the new sweep reg 9=0.
  - Assert rst at edge 10 of a sweep → ready rises 31 edges after the second release.
- Bypass (run both with and without REGFILE_BYPASS_EN): WE3=1, A3=A1=12, WD3=0x0BADF00D, with reg 12 previously 0x11111111 → pre-edge RD1=0x0BADF00D when defined, 0x11111111 when undefined.
